// File: rtl/uart_rx_loader.sv
// rtl/uart_rx_loader.sv - UART byte-stream packet loader driving memory writes and the console hold line
// Optional statistics counters: define UART_RX_LOADER_STATS_EN.
module uart_rx_loader #(
    parameter logic [7:0] HEADER         = 8'hA5,
    parameter int         ADDR_W         = 16,
    parameter int         TIMEOUT_CYCLES = 4000,
    parameter bit         HOLD_AT_RESET  = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic              sys_hold,
    output logic              busy,
    output logic              pkt_done,
    input  logic              err_clr,
    output logic              err_checksum,
    output logic              err_overrun,
    output logic              err_timeout,
    output logic              err_cmd
`ifdef UART_RX_LOADER_STATS_EN
    ,
    output logic [7:0]        pkt_count,
    output logic [7:0]        err_count
`endif
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CMD  = 3'd1;
    localparam logic [2:0] S_AHI  = 3'd2;
    localparam logic [2:0] S_ALO  = 3'd3;
    localparam logic [2:0] S_LEN  = 3'd4;
    localparam logic [2:0] S_DATA = 3'd5;
    localparam logic [2:0] S_CSUM = 3'd6;

    localparam int            TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_RELOAD = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]        state_q, state_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [7:0]        ahi_q, ahi_d;
    logic [7:0]        sum_q, sum_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic [8:0]        cnt_q, cnt_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              mem_we_q, mem_we_d;
    logic              sys_hold_q, sys_hold_d;
    logic              pkt_done_q, pkt_done_d;
    logic              err_csum_q, err_csum_d;
    logic              err_ovr_q, err_ovr_d;
    logic              err_tmo_q, err_tmo_d;
    logic              err_cmd_q, err_cmd_d;

    logic       set_csum, set_ovr, set_tmo, set_cmd, pkt_good;
    logic [7:0] sum_nxt;

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        ahi_d       = ahi_q;
        sum_d       = sum_q;
        addr_d      = addr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        mem_we_d    = mem_we_q;
        sys_hold_d  = sys_hold_q;
        pkt_done_d  = 1'b0;
        set_csum    = 1'b0;
        set_ovr     = 1'b0;
        set_tmo     = 1'b0;
        set_cmd     = 1'b0;
        pkt_good    = 1'b0;
        sum_nxt     = sum_q + rx_data;

        if (mem_we_q && mem_ready) begin
            mem_we_d = 1'b0;
        end

        if (rx_valid) begin
            tmo_d = TMO_RELOAD;
            case (state_q)
                S_IDLE: begin
                    if (rx_data == HEADER) begin
                        state_d = S_CMD;
                    end
                end
                S_CMD: begin
                    cmd_d   = rx_data;
                    sum_d   = rx_data;
                    state_d = S_AHI;
                end
                S_AHI: begin
                    ahi_d   = rx_data;
                    sum_d   = sum_nxt;
                    state_d = S_ALO;
                end
                S_ALO: begin
                    addr_d  = ADDR_W'({ahi_q, rx_data});
                    sum_d   = sum_nxt;
                    state_d = S_LEN;
                end
                S_LEN: begin
                    cnt_d   = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                    sum_d   = sum_nxt;
                    state_d = (cmd_q == 8'h01) ? S_DATA : S_CSUM;
                end
                S_DATA: begin
                    // A dropped byte still counts toward length and checksum so framing stays aligned
                    sum_d = sum_nxt;
                    cnt_d = cnt_q - 9'd1;
                    if (cnt_q == 9'd1) begin
                        state_d = S_CSUM;
                    end
                    if (mem_we_q && !mem_ready) begin
                        set_ovr = 1'b1;
                    end else begin
                        mem_we_d    = 1'b1;
                        mem_wdata_d = rx_data;
                        mem_addr_d  = addr_q;
                        addr_d      = addr_q + ADDR_W'(1);
                    end
                end
                S_CSUM: begin
                    pkt_done_d = 1'b1;
                    state_d    = S_IDLE;
                    if (sum_nxt == 8'h00) begin
                        pkt_good = 1'b1;
                        if (cmd_q == 8'h02) begin
                            sys_hold_d = 1'b1;
                        end else if (cmd_q == 8'h03) begin
                            sys_hold_d = 1'b0;
                        end
                    end else begin
                        set_csum = 1'b1;
                    end
                    if (cmd_q != 8'h01 && cmd_q != 8'h02 && cmd_q != 8'h03) begin
                        set_cmd = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            // Timeout abandons the packet but leaves any pending write to finish
            if (tmo_q == '0) begin
                state_d = S_IDLE;
                set_tmo = 1'b1;
            end else begin
                tmo_d = tmo_q - TW'(1);
            end
        end

        err_csum_d = set_csum ? 1'b1 : (err_clr ? 1'b0 : err_csum_q);
        err_ovr_d  = set_ovr  ? 1'b1 : (err_clr ? 1'b0 : err_ovr_q);
        err_tmo_d  = set_tmo  ? 1'b1 : (err_clr ? 1'b0 : err_tmo_q);
        err_cmd_d  = set_cmd  ? 1'b1 : (err_clr ? 1'b0 : err_cmd_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            ahi_q       <= '0;
            sum_q       <= '0;
            addr_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            mem_we_q    <= 1'b0;
            sys_hold_q  <= HOLD_AT_RESET;
            pkt_done_q  <= 1'b0;
            err_csum_q  <= 1'b0;
            err_ovr_q   <= 1'b0;
            err_tmo_q   <= 1'b0;
            err_cmd_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            ahi_q       <= ahi_d;
            sum_q       <= sum_d;
            addr_q      <= addr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            mem_we_q    <= mem_we_d;
            sys_hold_q  <= sys_hold_d;
            pkt_done_q  <= pkt_done_d;
            err_csum_q  <= err_csum_d;
            err_ovr_q   <= err_ovr_d;
            err_tmo_q   <= err_tmo_d;
            err_cmd_q   <= err_cmd_d;
        end
    end

    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_we       = mem_we_q;
    assign sys_hold     = sys_hold_q;
    assign busy         = (state_q != S_IDLE) || mem_we_q;
    assign pkt_done     = pkt_done_q;
    assign err_checksum = err_csum_q;
    assign err_overrun  = err_ovr_q;
    assign err_timeout  = err_tmo_q;
    assign err_cmd      = err_cmd_q;

`ifdef UART_RX_LOADER_STATS_EN
    logic [7:0] pkt_cnt_q, pkt_cnt_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic [1:0] n_err;
    logic [8:0] err_sum;

    always_comb begin
        n_err     = 2'(set_csum) + 2'(set_ovr) + 2'(set_tmo) + 2'(set_cmd);
        err_sum   = {1'b0, err_cnt_q} + 9'(n_err);
        err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
        pkt_cnt_d = (pkt_good && pkt_cnt_q != 8'hFF) ? pkt_cnt_q + 8'd1 : pkt_cnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign pkt_count = pkt_cnt_q;
    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_loader.sv
// tb/tb_uart_rx_loader.sv - directed self-checking bench for uart_rx_loader
module tb_uart_rx_loader;

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b0;
    logic [7:0]  rx_data   = 8'h00;
    logic        rx_valid  = 1'b0;
    logic        mem_ready = 1'b1;
    logic        err_clr   = 1'b0;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we, sys_hold, busy, pkt_done;
    logic        err_checksum, err_overrun, err_timeout, err_cmd;
`ifdef UART_RX_LOADER_STATS_EN
    logic [7:0]  pkt_count, err_count;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    int          pd_cnt   = 0;
    int          exp_pd   = 0;
    logic [15:0] wa[$];
    logic [7:0]  wd[$];
    logic [7:0]  q[$];

    always #5 clk = ~clk;

    uart_rx_loader dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_ready    (mem_ready),
        .sys_hold     (sys_hold),
        .busy         (busy),
        .pkt_done     (pkt_done),
        .err_clr      (err_clr),
        .err_checksum (err_checksum),
        .err_overrun  (err_overrun),
        .err_timeout  (err_timeout),
        .err_cmd      (err_cmd)
`ifdef UART_RX_LOADER_STATS_EN
        ,
        .pkt_count    (pkt_count),
        .err_count    (err_count)
`endif
    );

    // Inputs change 2ns after posedge, so a negedge sample sees what the next posedge will accept
    always @(negedge clk) begin
        if (reset_n && mem_we && mem_ready) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
        end
        if (pkt_done) pd_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #2;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #2;
        rx_valid = 1'b0;
    endtask

    task automatic send_q();
        foreach (q[i]) send_byte(q[i]);
    endtask

    task automatic clear_errs();
        @(posedge clk); #2;
        err_clr = 1'b1;
        @(posedge clk); #2;
        err_clr = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int bad;
        idle(3);
        @(negedge clk);
        check_eq("rst_we", mem_we, 0);
        check_eq("rst_hold", sys_hold, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_pd", pkt_done, 0);
        check_eq("rst_errs", {err_checksum, err_overrun, err_timeout, err_cmd}, 0);
        reset_n = 1'b1;
        idle(2);

        // Good two-byte write
        wa.delete(); wd.delete();
        q = '{8'hA5, 8'h01, 8'h80, 8'h00, 8'h02, 8'h11, 8'h22, 8'h4A};
        send_q(); exp_pd++;
        settle();
        check_eq("wr_count", wa.size(), 2);
        check_eq("wr0_addr", wa[0], 16'h8000);
        check_eq("wr0_data", wd[0], 8'h11);
        check_eq("wr1_addr", wa[1], 16'h8001);
        check_eq("wr1_data", wd[1], 8'h22);
        check_eq("wr_pd", pd_cnt, exp_pd);
        check_eq("wr_errs", {err_checksum, err_overrun, err_timeout, err_cmd}, 0);
        check_eq("wr_busy", busy, 0);

        // Hold release, assert, then bad-checksum release
        q = '{8'hA5, 8'h03, 8'h00, 8'h00, 8'h00, 8'hFD};
        send_q(); exp_pd++; settle();
        check_eq("rel_hold", sys_hold, 0);
        q = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'hFE};
        send_q(); exp_pd++; settle();
        check_eq("set_hold", sys_hold, 1);
        q = '{8'hA5, 8'h03, 8'h00, 8'h00, 8'h00, 8'hFF};
        send_q(); exp_pd++; settle();
        check_eq("bad_hold", sys_hold, 1);
        check_eq("bad_csum", err_checksum, 1);
        check_eq("hold_pd", pd_cnt, exp_pd);
        clear_errs(); settle();
        check_eq("clr_csum", err_checksum, 0);

        // Unknown command with a good checksum
        q = '{8'hA5, 8'h07, 8'h00, 8'h00, 8'h00, 8'hF9};
        send_q(); exp_pd++; settle();
        check_eq("unk_cmd", err_cmd, 1);
        check_eq("unk_csum", err_checksum, 0);
        check_eq("unk_hold", sys_hold, 1);
        clear_errs();

        // Backpressure: second payload byte arrives while the first write is stalled
        wa.delete(); wd.delete();
        q = '{8'hA5, 8'h01, 8'h80, 8'h00, 8'h02};
        send_q();
        mem_ready = 1'b0;
        send_byte(8'h11);
        @(negedge clk);
        check_eq("bp_we", mem_we, 1);
        check_eq("bp_addr0", mem_addr, 16'h8000);
        idle(100);
        send_byte(8'h22);
        @(negedge clk);
        check_eq("bp_ovr", err_overrun, 1);
        check_eq("bp_addr1", mem_addr, 16'h8000);
        check_eq("bp_data1", mem_wdata, 8'h11);
        idle(100);
        send_byte(8'h4A); exp_pd++;
        idle(100);
        mem_ready = 1'b1;
        settle();
        check_eq("bp_count", wa.size(), 1);
        check_eq("bp_wr_addr", wa[0], 16'h8000);
        check_eq("bp_csum", err_checksum, 0);
        check_eq("bp_pd", pd_cnt, exp_pd);
        clear_errs();

        // Timeout mid-header, then a normal packet
        q = '{8'hA5, 8'h01, 8'h80};
        send_q();
        idle(3000);
        check_eq("tmo_early", err_timeout, 0);
        check_eq("tmo_busy_early", busy, 1);
        idle(1100);
        check_eq("tmo_set", err_timeout, 1);
        check_eq("tmo_busy", busy, 0);
        wa.delete(); wd.delete();
        q = '{8'hA5, 8'h01, 8'h80, 8'h00, 8'h02, 8'h11, 8'h22, 8'h4A};
        send_q(); exp_pd++; settle();
        check_eq("tmo_after_cnt", wa.size(), 2);
        check_eq("tmo_after_addr", wa[1], 16'h8001);
        check_eq("tmo_after_pd", pd_cnt, exp_pd);
        clear_errs();

        // 256-byte payload wrapping past FFFF
        wa.delete(); wd.delete();
        q = '{8'hA5, 8'h01, 8'hFF, 8'hFF, 8'h00};
        for (int i = 0; i < 256; i++) q.push_back(8'(i));
        q.push_back(8'h81);
        send_q(); exp_pd++; settle();
        check_eq("wrap_count", wa.size(), 256);
        check_eq("wrap_a0", wa[0], 16'hFFFF);
        check_eq("wrap_d0", wd[0], 8'h00);
        check_eq("wrap_a1", wa[1], 16'h0000);
        check_eq("wrap_a255", wa[255], 16'h00FE);
        check_eq("wrap_d255", wd[255], 8'hFF);
        bad = 0;
        foreach (wa[i]) if (wa[i] !== 16'(i + 16'hFFFF) || wd[i] !== 8'(i)) bad++;
        check_eq("wrap_all", bad, 0);
        check_eq("wrap_pd", pd_cnt, exp_pd);
        check_eq("wrap_errs", {err_checksum, err_overrun, err_timeout, err_cmd}, 0);

        // Asynchronous reset while a write is pending
        q = '{8'hA5, 8'h03, 8'h00, 8'h00, 8'h00, 8'hFD};
        send_q(); exp_pd++; settle();
        check_eq("prerst_hold", sys_hold, 0);
        mem_ready = 1'b0;
        q = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h01, 8'h55};
        send_q();
        @(negedge clk);
        check_eq("prerst_we", mem_we, 1);
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        check_eq("arst_we", mem_we, 0);
        check_eq("arst_hold", sys_hold, 1);
        check_eq("arst_busy", busy, 0);
        idle(2);
        reset_n   = 1'b1;
        mem_ready = 1'b1;
        wa.delete(); wd.delete();
        q = '{8'h01, 8'h80, 8'h00, 8'h02, 8'h11, 8'h22, 8'h4A};
        send_q(); settle();
        check_eq("stray_wr", wa.size(), 0);
        check_eq("stray_pd", pd_cnt, exp_pd);
        check_eq("stray_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_loader.md
Name: uart_rx_loader

Overview:
- Packet parser and sequencer for the byte stream from the RS-232 receiver (`rx_data`/`rx_valid` strobe).
- Decodes framed command packets and drives byte writes into a memory port (PRG/CHR load) through a valid/ready handshake.
- Controls a system hold line that keeps the console core in reset while a program is being loaded.
- Sits between the UART receiver and the memory arbiter.

Parameters:
- HEADER, 8'hA5, sync byte that starts every packet.
- ADDR_W, 16, memory address width; upper bits above 16 are zero-filled from the address bytes.
- TIMEOUT_CYCLES, 4000, inter-byte timeout in clk cycles; must be at least 1.
- HOLD_AT_RESET, 1, reset value of sys_hold.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte, valid only when rx_valid=1
- rx_valid  in  1  one-cycle strobe per received byte
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  8  write data
- mem_we  out  1  write request (valid)
- mem_ready  in  1  memory accepts the write when mem_we&&mem_ready
- sys_hold  out  1  hold console core in reset
- busy  out  1  high in any state other than IDLE, or while mem_we=1
- pkt_done  out  1  one-cycle pulse when a packet's checksum byte has been received
- err_clr  in  1  clears all sticky error flags
- err_checksum  out  1  sticky: checksum mismatch
- err_overrun  out  1  sticky: payload byte dropped
- err_timeout  out  1  sticky: inter-byte timeout
- err_cmd  out  1  sticky: unknown command

Behaviour:
- Reset values: all outputs 0 except sys_hold=HOLD_AT_RESET; state=IDLE.
- Reset is asynchronous: mem_we drops immediately on assertion, even mid-packet.
- Packet format: HEADER, CMD, ADDR_HI, ADDR_LO, LEN, payload, CSUM.
  - Payload is present only for CMD=8'h01; LEN=0 means 256 bytes.
- Commands:
  - 01 = write.
  - 02 = assert sys_hold.
  - 03 = release sys_hold.
  - Any other value: no payload, no action; sets err_cmd at CSUM.
- States: IDLE -> CMD -> AHI -> ALO -> LEN -> (DATA if CMD=01, else CSUM) -> CSUM -> IDLE.
- Transitions occur only on rx_valid, except timeout.
- IDLE: advances only when rx_data==HEADER; all other bytes are ignored.
- Checksum: 8-bit sum of CMD, ADDR_HI, ADDR_LO, LEN, all payload bytes and CSUM must equal 8'h00.
  - The header byte is excluded from the sum.
- CSUM byte received:
  - pkt_done pulses the next cycle.
  - If the checksum is good, the 02/03 action is applied on that same edge.
  - If the checksum is bad, set err_checksum and take no hold action.
  - Writes already issued are not undone.
- DATA, per rx_valid:
  - Next cycle: mem_we=1, mem_wdata=byte, mem_addr=current address.
  - The address then post-increments, wrapping modulo 2^ADDR_W.
  - A remaining-byte counter (9 bits) decrements; at 0 the state moves to CSUM.
- Handshake:
  - mem_we stays high with mem_addr/mem_wdata stable until mem_ready=1.
  - mem_we deasserts the cycle after acceptance unless a new byte is loaded on the same edge.
- Simultaneous accept and new byte (mem_we&&mem_ready&&rx_valid in DATA): the new byte loads and mem_we stays high.
- Overrun (rx_valid in DATA while mem_we&&!mem_ready):
  - The byte is dropped and err_overrun is set.
  - The address does not advance; the counter and checksum still consume the byte.
- Timeout:
  - The counter reloads TIMEOUT_CYCLES-1 on every rx_valid.
  - It runs only outside IDLE; on reaching 0 the state returns to IDLE and err_timeout is set.
  - A pending write still completes.
- Error flags: err_clr clears all sticky flags; a same-cycle set wins over the clear.

Optional Feature:
- Macro: UART_RX_LOADER_STATS_EN.
- Defined:
  - Adds output ports pkt_count[7:0] (good-checksum packets) and err_count[7:0] (error events).
  - Both reset to 0, saturate at 8'hFF, and are not cleared by err_clr.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Good write: A5 01 80 00 02 11 22 4A, mem_ready=1 -> writes (8000,11) then (8001,22); pkt_done pulses once; no error flags.
- Hold control: A5 02 00 00 00 FE then A5 03 00 00 00 FD -> sys_hold=1 after the first CSUM and 0 after the second; CSUM FF in place of FD -> sys_hold stays 1, err_checksum=1.
- Backpressure: good write with mem_ready held 0 for 300 cycles while bytes arrive every 100 cycles -> first write stable; second byte dropped with err_overrun=1; address 8001 is not written.
- Timeout: A5 01 80, then silence > TIMEOUT_CYCLES -> err_timeout=1, state IDLE, busy=0; a following good packet is processed normally.
- Wrap and LEN=0: A5 01 FF FF 00 plus 256 bytes plus correct CSUM -> addresses FFFF, 0000 .. 00FE written; pkt_done pulses.
- Reset mid-payload: reset_n low while mem_we=1 -> mem_we=0 asynchronously, sys_hold=HOLD_AT_RESET; after release, stray bytes other than A5 are ignored.
